// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling stage: permutes S[0..255] in the shared single-port RAM using the latched key.
// Optional KSA_SKIP_SELF_SWAP_EN: iterations with i==j skip both write cycles.
module ksa_scheduler #(
  parameter int KEYLEN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rdy,
  input  logic [8*KEYLEN-1:0]   key,
  output logic [7:0]            addr,
  input  logic [7:0]            rddata,
  output logic [7:0]            wrdata,
  output logic                  wren
);

  localparam int KW = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;

  typedef enum logic [2:0] {IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J} state_t;

  state_t              state, state_d;
  logic [7:0]          i, i_d, j, j_d, si, si_d;
  logic [7:0]          addr_d, wrdata_d, kb;
  logic                wren_d, step;
  logic [KW-1:0]       kidx, kidx_d;
  logic [8*KEYLEN-1:0] key_q, key_d;

  assign rdy = (state == IDLE);

  // Key byte 0 is the most-significant byte of the latched key.
  always_comb begin
    kb = '0;
    for (int unsigned k = 0; k < KEYLEN; k++)
      if (kidx == KW'(k)) kb = key_q[8*(KEYLEN-1-k) +: 8];
  end

  // addr/wrdata/wren are registered: each state computes the value the next state presents.
  always_comb begin
    state_d  = state;
    i_d      = i;
    j_d      = j;
    si_d     = si;
    kidx_d   = kidx;
    key_d    = key_q;
    addr_d   = addr;
    wrdata_d = wrdata;
    wren_d   = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: if (en) begin
        key_d   = key;
        i_d     = '0;
        j_d     = '0;
        kidx_d  = '0;
        addr_d  = '0;
        state_d = RD_I;
      end
      RD_I: state_d = LD_I;
      LD_I: begin
        si_d    = rddata;
        j_d     = j + rddata + kb;
        addr_d  = j_d;
        state_d = RD_J;
      end
      RD_J: state_d = LD_J;
      LD_J: begin
`ifdef KSA_SKIP_SELF_SWAP_EN
        if (j == i) step = 1'b1;
        else
`endif
        begin
          addr_d   = i;
          wrdata_d = rddata;
          wren_d   = 1'b1;
          state_d  = WR_I;
        end
      end
      WR_I: begin
        addr_d   = j;
        wrdata_d = si;
        wren_d   = 1'b1;
        state_d  = WR_J;
      end
      WR_J: step = 1'b1;
      default: state_d = IDLE;
    endcase
    if (step) begin
      if (i == 8'hff) begin
        state_d = IDLE;
      end else begin
        i_d     = i + 8'd1;
        kidx_d  = (kidx == KW'(KEYLEN-1)) ? '0 : kidx + 1'b1;
        addr_d  = i + 8'd1;
        state_d = RD_I;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      si     <= '0;
      kidx   <= '0;
      key_q  <= '0;
      addr   <= '0;
      wrdata <= '0;
      wren   <= 1'b0;
    end else begin
      state  <= state_d;
      i      <= i_d;
      j      <= j_d;
      si     <= si_d;
      kidx   <= kidx_d;
      key_q  <= key_d;
      addr   <= addr_d;
      wrdata <= wrdata_d;
      wren   <= wren_d;
    end
  end

endmodule

// File: tb/tb_ksa_scheduler.sv
// Self-checking bench for ksa_scheduler: 1-cycle-latency RAM, software RC4 KSA reference model.
module tb_ksa_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy;
  logic [23:0] key = '0;
  logic [7:0]  addr, rddata, wrdata;
  logic        wren;

  ksa_scheduler #(.KEYLEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic        load = 1'b0;
  always @(posedge clk) begin
    if (load) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    else if (wren) mem[addr] <= wrdata;
    rddata <= mem[addr];
  end

  logic [15:0] wlog[$];
  bit          rec_on = 1'b0;
  always @(negedge clk) if (rec_on && wren === 1'b1) wlog.push_back({addr, wrdata});

  int n_checks = 0, n_errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: straight RC4 KSA on an integer array.
  int          ms[256];
  logic [15:0] exp_w[$];
  int          exp_busy;
  task automatic model(input logic [23:0] k);
    int jj, t, kb, selfc;
    bit skip;
`ifdef KSA_SKIP_SELF_SWAP_EN
    skip = 1'b1;
`else
    skip = 1'b0;
`endif
    for (int n = 0; n < 256; n++) ms[n] = n;
    exp_w.delete();
    jj = 0; selfc = 0;
    for (int n = 0; n < 256; n++) begin
      kb = int'((k >> (8 * (2 - n % 3))) & 24'hff);
      jj = (jj + ms[n] + kb) % 256;
      if (jj == n) selfc++;
      if (!(skip && jj == n)) begin
        exp_w.push_back(16'((n << 8) | ms[jj]));
        exp_w.push_back(16'((jj << 8) | ms[n]));
      end
      t = ms[n]; ms[n] = ms[jj]; ms[jj] = t;
    end
    exp_busy = skip ? 1536 - 2 * selfc : 1536;
  endtask

  task automatic preload();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  int last_busy;
  bit timed_out;
  task automatic run(input logic [23:0] k, input bit disturb, input int rst_at);
    preload();
    model(k);
    wlog.delete();
    rec_on = 1'b1;
    @(negedge clk); key = k; en = 1'b1;
    @(negedge clk); en = 1'b0;
    last_busy = 0;
    timed_out = 1'b0;
    while (!rdy) begin
      last_busy++;
      if (last_busy >= 3000) begin timed_out = 1'b1; break; end
      if (last_busy == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdy", int'(rdy), 1);
        chk("async_rst_wren", int'(wren), 0);
        chk("async_rst_addr", int'(addr), 0);
        @(negedge clk); rst_n = 1'b1;
        rec_on = 1'b0;
        return;
      end
      if (disturb) begin
        if (last_busy == 10) en = 1'b1;
        if (last_busy == 11) en = 1'b0;
        if (last_busy >= 5 && last_busy < 300) key = $urandom;
      end
      @(negedge clk);
    end
    rec_on = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int bad;
    chk({tag, "_timeout"}, int'(timed_out), 0);
    chk({tag, "_busy"}, last_busy, exp_busy);
    chk({tag, "_nwrites"}, wlog.size(), exp_w.size());
    bad = 0;
    for (int n = 0; n < exp_w.size() && n < wlog.size(); n++)
      if (wlog[n] !== exp_w[n]) bad++;
    chk({tag, "_write_mismatches"}, bad, 0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (int'(mem[n]) != ms[n]) bad++;
    chk({tag, "_final_S_mismatches"}, bad, 0);
  endtask

  typedef struct {
    logic [23:0] key;
    int          widx;
    logic [7:0]  a;
    logic [7:0]  d;
  } vec_t;
  vec_t tbl[8];

  task automatic check_table(input logic [23:0] k);
    for (int n = 0; n < 8; n++) begin
      if (tbl[n].key != k) continue;
      if (tbl[n].widx < wlog.size())
        chk($sformatf("write%0d_key%06h", tbl[n].widx, k), int'(wlog[tbl[n].widx]),
            int'({tbl[n].a, tbl[n].d}));
      else
        chk($sformatf("write%0d_key%06h_missing", tbl[n].widx, k), wlog.size(), tbl[n].widx + 1);
    end
  endtask

  initial begin
`ifdef KSA_SKIP_SELF_SWAP_EN
    tbl = '{'{24'h00033C, 0, 8'h01, 8'h04}, '{24'h00033C, 1, 8'h04, 8'h01},
            '{24'h00033C, 2, 8'h02, 8'h42}, '{24'h00033C, 3, 8'h42, 8'h02},
            '{24'h000000, 0, 8'h02, 8'h03}, '{24'h000000, 1, 8'h03, 8'h02},
            '{24'h000000, 2, 8'h03, 8'h05}, '{24'h000000, 3, 8'h05, 8'h02}};
`else
    tbl = '{'{24'h00033C, 0, 8'h00, 8'h00}, '{24'h00033C, 2, 8'h01, 8'h04},
            '{24'h00033C, 4, 8'h02, 8'h42}, '{24'h00033C, 5, 8'h42, 8'h02},
            '{24'h000000, 2, 8'h01, 8'h01}, '{24'h000000, 4, 8'h02, 8'h03},
            '{24'h000000, 6, 8'h03, 8'h05}, '{24'h000000, 7, 8'h05, 8'h02}};
`endif
    #1;
    chk("reset_rdy", int'(rdy), 1);
    chk("reset_wren", int'(wren), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_wrdata", int'(wrdata), 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    wlog.delete(); rec_on = 1'b1;
    repeat (100) @(negedge clk);
    rec_on = 1'b0;
    chk("idle_no_writes", wlog.size(), 0);
    chk("idle_rdy", int'(rdy), 1);

    run(24'h00033C, 1'b0, -1);
    check_run("key33c");
    check_table(24'h00033C);

    run(24'h000000, 1'b0, -1);
    check_run("key0");
    check_table(24'h000000);

    run(24'h00033C, 1'b1, -1);
    check_run("disturbed");

    run(24'h00033C, 1'b0, 700);
    run(24'h00033C, 1'b0, -1);
    check_run("after_reset");
    check_table(24'h00033C);

    for (int r = 0; r < 4; r++) begin
      run(24'($urandom), 1'b0, -1);
      check_run($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ksa_scheduler.md
Name: ksa_scheduler

Overview:
- RC4 key-scheduling stage for the ARC4 decryption datapath.
- Sits directly downstream of the S-array init stage, which leaves S[i]=i, i=0..255, in the shared 256x8 single-port on-chip RAM.
- Permutes S in place using the secret key, driving the RAM's address/data/write-enable port.
- Hands the scrambled S to the downstream PRGA/decrypt stage through the team's en/rdy handshake.

Parameters:
KEYLEN, 3, key length in bytes; key port is 8*KEYLEN bits, most-significant byte is key byte 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  start request; sampled only while rdy=1.
rdy  output  1  high when idle and able to accept en.
key  input  8*KEYLEN  secret key; captured on the accepted en edge.
addr  output  8  S-RAM address.
rddata  input  8  S-RAM read data; valid one cycle after addr is presented (registered address).
wrdata  output  8  S-RAM write data.
wren  output  1  S-RAM write enable.

Behaviour:
- Reset (asynchronous, any time, including mid-run) forces state IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, kidx=0, latched key=0.
- Handshake:
  - In IDLE with rdy=1, an en high at a rising edge latches key, clears i, j and kidx, drops rdy, and enters RD_I.
  - en while rdy=0 is ignored.
  - en held high across completion restarts a new run on the first edge where rdy=1.
- State machine, with all arithmetic mod 256 (8-bit wrap) and i, j, kidx as registers:
  - RD_I: addr=i, wren=0 -> LD_I.
  - LD_I: si<=rddata; j<=j+rddata+kb -> RD_J.
  - RD_J: addr=j, wren=0 -> LD_J.
  - LD_J: sj<=rddata -> WR_I.
  - WR_I: addr=i, wrdata=sj, wren=1 -> WR_J.
  - WR_J: addr=j, wrdata=si, wren=1.
    - If i==255 -> IDLE with rdy=1.
    - Else i<=i+1, kidx<=(kidx==KEYLEN-1)?0:kidx+1 -> RD_I.
- kb = key byte kidx = latched_key[8*(KEYLEN-1-kidx) +: 8]. No divider; kidx is a wrap counter.
- Latency: 6 cycles per index. rdy is low for exactly 1536 cycles from the accepting edge; rdy=1 again in cycle 1537.
- i==j: both writes go to the same address with identical data; S is unchanged. Still 6 cycles.
- wren is asserted only in WR_I and WR_J. addr and wrdata are held at their last value in IDLE (0 after reset).
- The key port may change freely while busy; only the latched copy is used.

Optional Feature:
- Macro: KSA_SKIP_SELF_SWAP_EN.
- Defined: in LD_J (one cycle after RD_J), if j==i, skip WR_I and WR_J and go directly to the increment/exit decision. That iteration takes 4 cycles and issues no writes. Total busy time = 1536 - 2*(number of i with i==j).
- Not defined: every iteration takes 6 cycles and issues 2 writes, as above.

Test Plan:
- Bench setup: behavioural 1-cycle-latency 256x8 RAM preloaded S[i]=i; KEYLEN=3.
- Reset idle: rst_n=0 -> rdy=1, wren=0, addr=0. Release, no en -> no writes for 100 cycles.
- Key 24'h00033C -> first three write pairs:
  - i=0: (addr0<-0, addr0<-0).
  - i=1: (addr1<-4, addr4<-1).
  - i=2: (addr2<-0x42, addr0x42<-2).
  - rdy low exactly 1536 cycles; final RAM matches the software RC4 KSA model.
- Key 24'h000000 -> writes:
  - i=1: addr1<-1 twice (self-swap).
  - i=2: addr2<-3, addr3<-2.
  - i=3: addr3<-5, addr5<-2.
  - Final S matches the model.
- Same key with KSA_SKIP_SELF_SWAP_EN defined:
  - No writes for i=0 or i=1; first write is addr2<-3.
  - Busy time = 1536 - 2*(self-swap count from model).
- en pulsed at cycle 10 of a run, and key port toggled mid-run -> no restart; result identical to the undisturbed run.
- rst_n low at cycle 700 -> wren=0, rdy=1 immediately (asynchronous).
  - Release and re-preload RAM, then en with key 24'h00033C -> full correct 1536-cycle run.
